scroll_accumulator: RTL and testbench
=====================================

// Module: scroll_accumulator
// PURPOSE
//   Parametrised successor to the lab calculator datapath. One block owns the button
//   synchroniser, a WIDTH-bit add/subtract accumulator with wrap or saturate overflow,
//   the scroll-tick divider and a DIGITS-wide 7-segment window. When the sum has more
//   hex nibbles than there are display digits, the window scrolls across the sum.
//   Sits between the board I/O (switches/buttons) and the SSD pins.
// PARAMETERS
//   WIDTH   8    accumulator width in bits; multiple of 4, range 4..32
//   DIGITS  4    number of SSD digits driven, range 1..8
//   DIV     20000000  clk cycles per scroll tick (5 Hz at 100 MHz), >=2
//   SAT     0    0 = wrap on overflow/underflow; 1 = clamp to all-ones/zero
// PORTS
//   clk           in   1           system clock; all state on rising edge
//   rst           in   1           synchronous reset, active-low
//   btn           in   1           raw (already debounced) apply button, asynchronous
//   clr           in   1           synchronous clear of sum and overflow, active-high
//   op            in   1           0 = add, 1 = subtract
//   P             in   1           1 = pause scrolling
//   addend        in   4           operand, zero-extended to WIDTH
//   sum           out  WIDTH       accumulator value
//   overflow_led  out  1           sticky overflow/underflow flag
//   win_ofs       out  8           current window offset in nibbles (for debug/verification)
//   seg           out  DIGITS*7    digit d at [7d+6:7d], active-high, bit order {g,f,e,d,c,b,a}
// BEHAVIOUR
//   Reset (rst=0 at an edge): sum=0, overflow_led=0, win_ofs=0, tick counter=0,
//     sync flops s1/s2/s3=0. Reset has priority over everything else.
//   Button path: s1<=btn, s2<=s1, s3<=s2; press = s2 & ~s3 (one-cycle pulse).
//     The edge E0 at which s1 first captures 1 is followed by E1 (press high) and
//     E2 (sum/overflow updated). A held button yields exactly one update.
//   Accumulator (priority rst > clr > press):
//     clr=1: sum<=0, overflow_led<=0, regardless of press.
//     press, op=0: r = sum + addend, WIDTH+1 bits. If the carry is set, overflow_led<=1
//       and sum<=SAT ? all-ones : r[WIDTH-1:0].
//     press, op=1: r = sum - addend. If there is a borrow, overflow_led<=1 and
//       sum<=SAT ? 0 : r mod 2^WIDTH.
//     overflow_led stays set until rst or clr. Operations without overflow do not clear it.
//   Tick: counter runs 0..DIV-1 and wraps. tick=1 in the cycle where count==DIV-1.
//     The counter free-runs while P=1.
//   Window: NIB = WIDTH/4, MAXOFS = NIB-DIGITS.
//     NIB<=DIGITS: win_ofs is held at 0. Digits with index >= NIB are blank (7'h00).
//     NIB>DIGITS: on tick with P=0, win_ofs <= (win_ofs==MAXOFS) ? 0 : win_ofs+1.
//       P=1 freezes win_ofs. clr does not affect win_ofs.
//   seg (combinational from registers): digit d shows hex nibble (win_ofs+d) of sum,
//     using the standard hex font (0=7'h3F, 1=7'h06 ... F=7'h71). Digit 0 is the rightmost.
//   No latency exists between a sum/win_ofs register change and seg.
// TESTING (WIDTH=8, DIGITS=4, DIV=4 unless stated)
//   1 Reset: hold rst=0 for 2 edges -> sum=0, overflow_led=0, seg digits 1/0=7'h3F,
//     digits 3/2=7'h00, win_ofs=0.
//   2 Add wrap: addend=F, op=0, press 17x -> sum=8'hFF, ovf=0. 18th press -> sum=8'h0E,
//     ovf=1. With SAT=1 the 18th press gives sum=8'hFF, ovf=1.
//   3 Subtract underflow: sum=0, op=1, addend=1, press -> SAT=0: sum=8'hFF, ovf=1;
//     SAT=1: sum=8'h00, ovf=1. A following add of 1 leaves ovf=1.
//   4 Latency/hold: btn rises before edge E0 and is held for 100 cycles -> sum changes
//     exactly at E2, exactly once. A second press after release gives one more update.
//   5 Scroll: WIDTH=24, sum=24'h123456, P=0 -> win_ofs steps 0,1,2,0 every 4 cycles and
//     digit0 shows 6,5,4,6. P=1 -> win_ofs frozen for 20 cycles.
//   6 Conflicts: clr and press in the same cycle -> sum=0, ovf=0. rst=0 with win_ofs=2
//     mid-scroll -> win_ofs=0 and counter=0 at the next edge.

Source files
------------

// File: rtl/scroll_accumulator_if.sv
// Board-side bundle for the scroll accumulator: operator controls in, sum and display out.
interface scroll_accumulator_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 4
);
  logic                  btn;
  logic                  clr;
  logic                  op;
  logic                  P;
  logic [3:0]            addend;
  logic [WIDTH-1:0]      sum;
  logic                  overflow_led;
  logic [7:0]            win_ofs;
  logic [DIGITS*7-1:0]   seg;

  // Board I/O side drives the controls and observes the results.
  modport master (
    output btn, clr, op, P, addend,
    input  sum, overflow_led, win_ofs, seg
  );

  // Datapath side.
  modport slave (
    input  btn, clr, op, P, addend,
    output sum, overflow_led, win_ofs, seg
  );
endinterface

// File: rtl/scroll_accumulator.sv
// Button-driven add/subtract accumulator with a scrolling hex 7-segment window.
module scroll_accumulator #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 20000000,
  parameter bit          SAT    = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  scroll_accumulator_if.slave  bus
);

  localparam int unsigned CW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int          Nib     = int'(WIDTH / 4);
  localparam int          MaxOfs  = (Nib > int'(DIGITS)) ? Nib - int'(DIGITS) : 0;
  localparam logic [7:0]  MaxOfsB = 8'(MaxOfs);

  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       win_q, win_d;
  logic             press, tick;
  logic [WIDTH:0]   add_r, sub_r;
  logic [WIDTH:0]   ext;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    unique case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Next-state for accumulator, tick divider and window offset.
  always_comb begin
    press = s2_q & ~s3_q;
    tick  = (cnt_q == CW'(DIV - 1));
    ext   = {{(WIDTH - 3){1'b0}}, bus.addend};
    add_r = {1'b0, sum_q} + ext;
    sub_r = {1'b0, sum_q} - ext;
    sum_d = sum_q;
    ovf_d = ovf_q;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    win_d = win_q;

    if (bus.clr) begin
      sum_d = '0;
      ovf_d = 1'b0;
    end else if (press) begin
      if (!bus.op) begin
        if (add_r[WIDTH]) begin
          ovf_d = 1'b1;
          sum_d = SAT ? '1 : add_r[WIDTH-1:0];
        end else begin
          sum_d = add_r[WIDTH-1:0];
        end
      end else begin
        // Bit WIDTH of the extended difference is the borrow.
        if (sub_r[WIDTH]) begin
          ovf_d = 1'b1;
          sum_d = SAT ? '0 : sub_r[WIDTH-1:0];
        end else begin
          sum_d = sub_r[WIDTH-1:0];
        end
      end
    end

    if ((Nib > int'(DIGITS)) && tick && !bus.P) begin
      win_d = (win_q == MaxOfsB) ? 8'd0 : win_q + 8'd1;
    end
  end

  // State registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      sum_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      win_q <= 8'd0;
    end else begin
      s1_q  <= bus.btn;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      win_q <= win_d;
    end
  end

  // Display window: digit d shows nibble (win_ofs + d); positions past the sum are blank.
  always_comb begin
    int pos;
    bus.seg = '0;
    for (int d = 0; d < int'(DIGITS); d++) begin
      pos = int'(win_q) + d;
      if (pos < Nib) begin
        bus.seg[7*d +: 7] = hex7(4'(sum_q >> (4 * pos)));
      end
    end
  end

  assign bus.sum          = sum_q;
  assign bus.overflow_led = ovf_q;
  assign bus.win_ofs      = win_q;

endmodule

// File: tb/tb_scroll_accumulator.sv
// Directed bench: two 8-bit instances (wrap and saturate) and one 24-bit scrolling instance.
module tb_scroll_accumulator;

  logic       clk;
  logic       rst;
  logic       btn, clr, op, P;
  logic [3:0] addend;

  int tests;
  int fails;

  scroll_accumulator_if #(.WIDTH(8),  .DIGITS(4)) if_a ();
  scroll_accumulator_if #(.WIDTH(8),  .DIGITS(4)) if_b ();
  scroll_accumulator_if #(.WIDTH(24), .DIGITS(4)) if_c ();

  assign if_a.btn = btn;  assign if_a.clr = clr;  assign if_a.op = op;
  assign if_a.P = P;      assign if_a.addend = addend;
  assign if_b.btn = btn;  assign if_b.clr = clr;  assign if_b.op = op;
  assign if_b.P = P;      assign if_b.addend = addend;
  assign if_c.btn = btn;  assign if_c.clr = clr;  assign if_c.op = op;
  assign if_c.P = P;      assign if_c.addend = addend;

  scroll_accumulator #(.WIDTH(8), .DIGITS(4), .DIV(4), .SAT(1'b0)) dut_a (
    .clk (clk), .rst (rst), .bus (if_a.slave)
  );
  scroll_accumulator #(.WIDTH(8), .DIGITS(4), .DIV(4), .SAT(1'b1)) dut_b (
    .clk (clk), .rst (rst), .bus (if_b.slave)
  );
  scroll_accumulator #(.WIDTH(24), .DIGITS(4), .DIV(4), .SAT(1'b0)) dut_c (
    .clk (clk), .rst (rst), .bus (if_c.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       op;
    logic [3:0] addend;
    logic [7:0] sum_a;
    logic       ovf_a;
    logic [7:0] sum_b;
    logic       ovf_b;
  } vec_t;

  vec_t vecs[23];

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[n];
  endfunction

  function automatic logic [27:0] seg8(input logic [7:0] s);
    return {7'h00, 7'h00, font(s[7:4]), font(s[3:0])};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic o, input logic [3:0] a);
    op = o;
    addend = a;
    btn = 1'b1;
    step(3);
    btn = 1'b0;
    step(3);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0] nib_c [6];
    int changes;
    int exp_ofs;
    int guard;

    tests = 0;
    fails = 0;
    rst = 1'b1; btn = 1'b0; clr = 1'b0; op = 1'b0; P = 1'b0; addend = 4'h0;

    // Vector table: 17 adds of F, wrap/sat add, clear, underflow, sticky flag.
    for (int i = 0; i < 17; i++) begin
      vecs[i] = '{1'b0, 1'b0, 4'hF, 8'(15 * (i + 1)), 1'b0, 8'(15 * (i + 1)), 1'b0};
    end
    vecs[17] = '{1'b0, 1'b0, 4'hF, 8'h0E, 1'b1, 8'hFF, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 4'h1, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 4'h1, 8'h00, 1'b1, 8'h01, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 4'h2, 8'h02, 1'b1, 8'h03, 1'b1};
    vecs[22] = '{1'b0, 1'b1, 4'h3, 8'hFF, 1'b1, 8'h00, 1'b1};

    // Reset state.
    do_reset();
    check("reset_sum_a", 64'(if_a.sum), 64'h0);
    check("reset_ovf_a", 64'(if_a.overflow_led), 64'h0);
    check("reset_seg_a", 64'(if_a.seg), 64'(seg8(8'h00)));
    check("reset_win_a", 64'(if_a.win_ofs), 64'h0);
    check("reset_win_c", 64'(if_c.win_ofs), 64'h0);
    check("reset_seg_c", 64'(if_c.seg), 64'({4{7'h3F}}));

    // Latency and held button: one update, exactly at E2.
    op = 1'b0;
    addend = 4'h5;
    btn = 1'b1;
    step();
    check("lat_e0", 64'(if_a.sum), 64'h0);
    step();
    check("lat_e1", 64'(if_a.sum), 64'h0);
    step();
    check("lat_e2", 64'(if_a.sum), 64'h05);
    changes = 0;
    for (int i = 0; i < 97; i++) begin
      step();
      if (if_a.sum !== 8'h05) changes++;
    end
    check("hold_single_update", 64'(changes), 64'h0);
    btn = 1'b0;
    step(3);
    press(1'b0, 4'h5);
    check("second_press", 64'(if_a.sum), 64'h0A);

    // Table-driven accumulator vectors.
    do_reset();
    for (int i = 0; i < 23; i++) begin
      if (vecs[i].clr) begin
        clr = 1'b1;
        step();
        clr = 1'b0;
      end else begin
        press(vecs[i].op, vecs[i].addend);
      end
      check($sformatf("vec%0d_sum_wrap", i), 64'(if_a.sum), 64'(vecs[i].sum_a));
      check($sformatf("vec%0d_ovf_wrap", i), 64'(if_a.overflow_led), 64'(vecs[i].ovf_a));
      check($sformatf("vec%0d_sum_sat", i), 64'(if_b.sum), 64'(vecs[i].sum_b));
      check($sformatf("vec%0d_ovf_sat", i), 64'(if_b.overflow_led), 64'(vecs[i].ovf_b));
      check($sformatf("vec%0d_seg_wrap", i), 64'(if_a.seg), 64'(seg8(vecs[i].sum_a)));
    end
    check("win_a_static", 64'(if_a.win_ofs), 64'h0);

    // clr and press landing on the same edge: clear wins.
    op = 1'b0;
    addend = 4'h1;
    btn = 1'b1;
    step(2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_press_sum_a", 64'(if_a.sum), 64'h0);
    check("clr_press_ovf_a", 64'(if_a.overflow_led), 64'h0);
    check("clr_press_ovf_b", 64'(if_b.overflow_led), 64'h0);
    btn = 1'b0;
    step(3);
    check("clr_press_after", 64'(if_a.sum), 64'h0);

    // Scroll: build 24'hFFFFE1 with scrolling frozen.
    do_reset();
    P = 1'b1;
    press(1'b1, 4'h1);
    press(1'b1, 4'hF);
    press(1'b1, 4'hF);
    check("c_sum", 64'(if_c.sum), 64'hFFFFE1);
    check("c_frozen_setup", 64'(if_c.win_ofs), 64'h0);
    nib_c = '{4'h1, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF};
    P = 1'b0;
    guard = 0;
    while (if_c.win_ofs == 8'd0 && guard < 8) begin
      step();
      guard++;
    end
    check("scroll_first", 64'(if_c.win_ofs), 64'h1);
    for (int j = 1; j <= 12; j++) begin
      step();
      exp_ofs = (1 + j / 4) % 3;
      check($sformatf("scroll_ofs_%0d", j), 64'(if_c.win_ofs), 64'(exp_ofs));
      check($sformatf("scroll_dig0_%0d", j), 64'(if_c.seg[6:0]), 64'(font(nib_c[exp_ofs])));
      check($sformatf("scroll_dig3_%0d", j), 64'(if_c.seg[27:21]),
            64'(font(nib_c[exp_ofs + 3])));
    end
    P = 1'b1;
    changes = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (if_c.win_ofs !== 8'd1) changes++;
    end
    check("pause_frozen", 64'(changes), 64'h0);

    // Reset mid-scroll clears offset and divider phase.
    P = 1'b0;
    guard = 0;
    while (if_c.win_ofs != 8'd2 && guard < 8) begin
      step();
      guard++;
    end
    check("reach_ofs2", 64'(if_c.win_ofs), 64'h2);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rst_mid_ofs", 64'(if_c.win_ofs), 64'h0);
    check("rst_mid_sum", 64'(if_c.sum), 64'h0);
    for (int j = 1; j <= 4; j++) begin
      step();
      check($sformatf("post_rst_ofs_%0d", j), 64'(if_c.win_ofs), (j == 4) ? 64'h1 : 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
